// File: rtl/bp_fe_icache_fill_responder.sv
// rtl/bp_fe_icache_fill_responder.sv - I-cache miss fill responder: one miss, beat-wise fetch, data/tag/stat fill packets
module bp_fe_icache_fill_responder #(
    parameter int paddr_width_p        = 40,
    parameter int icache_sets_p        = 64,
    parameter int icache_assoc_p       = 8,
    parameter int icache_block_width_p = 512,
    parameter int mem_data_width_p     = 64,
    parameter int ptag_width_p         = 28,
    localparam int index_width_lp        = $clog2(icache_sets_p),
    localparam int way_width_lp          = $clog2(icache_assoc_p),
    localparam int block_offset_width_lp = $clog2(icache_block_width_p / 8),
    localparam int beats_lp              = icache_block_width_p / mem_data_width_p,
    localparam int beat_width_lp         = $clog2(beats_lp)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [paddr_width_p-1:0]        cache_req_addr_i,
    input  logic                            cache_req_v_i,
    output logic                            cache_req_ready_o,
    input  logic [way_width_lp-1:0]         cache_req_metadata_way_i,
    input  logic                            cache_req_metadata_v_i,
    output logic [paddr_width_p-1:0]        mem_cmd_addr_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic [mem_data_width_p-1:0]     mem_resp_data_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o,
    output logic [index_width_lp-1:0]       data_mem_pkt_index_o,
    output logic [way_width_lp-1:0]         data_mem_pkt_way_o,
    output logic [icache_block_width_p-1:0] data_mem_pkt_data_o,
    output logic                            data_mem_pkt_v_o,
    input  logic                            data_mem_pkt_ready_i,
    output logic [index_width_lp-1:0]       tag_mem_pkt_index_o,
    output logic [way_width_lp-1:0]         tag_mem_pkt_way_o,
    output logic [ptag_width_p-1:0]         tag_mem_pkt_tag_o,
    output logic                            tag_mem_pkt_v_o,
    input  logic                            tag_mem_pkt_ready_i,
    output logic [index_width_lp-1:0]       stat_mem_pkt_index_o,
    output logic [way_width_lp-1:0]         stat_mem_pkt_way_o,
    output logic                            stat_mem_pkt_v_o,
    input  logic                            stat_mem_pkt_ready_i,
    output logic                            cache_req_complete_o
);

    typedef enum logic [2:0] {
        IDLE, WAIT_META, SEND_MEM, FILL, WR_DATA, WR_TAG, WR_STAT, DONE
    } state_e;

    state_e                          state_r, state_n;
    logic                            started_r;
    logic [paddr_width_p-1:0]        addr_r;
    logic [way_width_lp-1:0]         way_r;
    logic [icache_block_width_p-1:0] block_r;
    logic [beat_width_lp-1:0]        beat_cnt_r;

    // started_r keeps ready low while in reset and until the first edge after release
    logic req_fire, meta_take, beat_take, last_beat;
    assign req_fire  = started_r && (state_r == IDLE) && cache_req_v_i;
    assign meta_take = cache_req_metadata_v_i && (req_fire || (state_r == WAIT_META));
    assign beat_take = (state_r == FILL) && mem_resp_v_i;
    assign last_beat = (beat_cnt_r == beat_width_lp'(beats_lp - 1));

    // State register and out-of-reset flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            started_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            started_r <= 1'b1;
        end
    end

    // Next-state selection
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:      if (req_fire) state_n = cache_req_metadata_v_i ? SEND_MEM : WAIT_META;
            WAIT_META: if (cache_req_metadata_v_i) state_n = SEND_MEM;
            SEND_MEM:  if (mem_cmd_ready_i) state_n = FILL;
            FILL:      if (beat_take && last_beat) state_n = WR_DATA;
            WR_DATA:   if (data_mem_pkt_ready_i) state_n = WR_TAG;
            WR_TAG:    if (tag_mem_pkt_ready_i) state_n = WR_STAT;
            WR_STAT:   if (stat_mem_pkt_ready_i) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        cache_req_ready_o    = 1'b0;
        mem_cmd_v_o          = 1'b0;
        mem_resp_yumi_o      = 1'b0;
        data_mem_pkt_v_o     = 1'b0;
        tag_mem_pkt_v_o      = 1'b0;
        stat_mem_pkt_v_o     = 1'b0;
        cache_req_complete_o = 1'b0;
        case (state_r)
            IDLE:     cache_req_ready_o    = started_r;
            SEND_MEM: mem_cmd_v_o          = 1'b1;
            FILL:     mem_resp_yumi_o      = mem_resp_v_i;
            WR_DATA:  data_mem_pkt_v_o     = 1'b1;
            WR_TAG:   tag_mem_pkt_v_o      = 1'b1;
            WR_STAT:  stat_mem_pkt_v_o     = 1'b1;
            DONE:     cache_req_complete_o = 1'b1;
            default:  ;
        endcase
    end

    // Miss address, victim way, beat assembly and beat counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_r     <= '0;
            way_r      <= '0;
            block_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            if (req_fire)  addr_r <= cache_req_addr_i;
            if (meta_take) way_r  <= cache_req_metadata_way_i;
            if (beat_take) begin
                block_r[beat_cnt_r*mem_data_width_p +: mem_data_width_p] <= mem_resp_data_i;
                beat_cnt_r <= beat_cnt_r + 1'b1;
            end
        end
    end

    // Fetch is always for the whole block, so the offset bits are cleared
    assign mem_cmd_addr_o = addr_r & ~paddr_width_p'(icache_block_width_p / 8 - 1);

    assign data_mem_pkt_index_o = addr_r[block_offset_width_lp +: index_width_lp];
    assign data_mem_pkt_way_o   = way_r;
    assign data_mem_pkt_data_o  = block_r;
    assign tag_mem_pkt_index_o  = addr_r[block_offset_width_lp +: index_width_lp];
    assign tag_mem_pkt_way_o    = way_r;
    assign tag_mem_pkt_tag_o    = addr_r[paddr_width_p-1 -: ptag_width_p];
    assign stat_mem_pkt_index_o = addr_r[block_offset_width_lp +: index_width_lp];
    assign stat_mem_pkt_way_o   = way_r;

endmodule

// File: tb/tb_bp_fe_icache_fill_responder.sv
// tb/tb_bp_fe_icache_fill_responder.sv - scoreboard bench for bp_fe_icache_fill_responder
module tb_bp_fe_icache_fill_responder;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [39:0]  cache_req_addr_i;
    logic         cache_req_v_i;
    logic         cache_req_ready_o;
    logic [2:0]   cache_req_metadata_way_i;
    logic         cache_req_metadata_v_i;
    logic [39:0]  mem_cmd_addr_o;
    logic         mem_cmd_v_o;
    logic         mem_cmd_ready_i;
    logic [63:0]  mem_resp_data_i;
    logic         mem_resp_v_i;
    logic         mem_resp_yumi_o;
    logic [5:0]   data_mem_pkt_index_o;
    logic [2:0]   data_mem_pkt_way_o;
    logic [511:0] data_mem_pkt_data_o;
    logic         data_mem_pkt_v_o;
    logic         data_mem_pkt_ready_i;
    logic [5:0]   tag_mem_pkt_index_o;
    logic [2:0]   tag_mem_pkt_way_o;
    logic [27:0]  tag_mem_pkt_tag_o;
    logic         tag_mem_pkt_v_o;
    logic         tag_mem_pkt_ready_i;
    logic [5:0]   stat_mem_pkt_index_o;
    logic [2:0]   stat_mem_pkt_way_o;
    logic         stat_mem_pkt_v_o;
    logic         stat_mem_pkt_ready_i;
    logic         cache_req_complete_o;

    bp_fe_icache_fill_responder dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cache_req_addr_i(cache_req_addr_i), .cache_req_v_i(cache_req_v_i),
        .cache_req_ready_o(cache_req_ready_o),
        .cache_req_metadata_way_i(cache_req_metadata_way_i),
        .cache_req_metadata_v_i(cache_req_metadata_v_i),
        .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_v_o(mem_cmd_v_o),
        .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_yumi_o(mem_resp_yumi_o),
        .data_mem_pkt_index_o(data_mem_pkt_index_o), .data_mem_pkt_way_o(data_mem_pkt_way_o),
        .data_mem_pkt_data_o(data_mem_pkt_data_o), .data_mem_pkt_v_o(data_mem_pkt_v_o),
        .data_mem_pkt_ready_i(data_mem_pkt_ready_i),
        .tag_mem_pkt_index_o(tag_mem_pkt_index_o), .tag_mem_pkt_way_o(tag_mem_pkt_way_o),
        .tag_mem_pkt_tag_o(tag_mem_pkt_tag_o), .tag_mem_pkt_v_o(tag_mem_pkt_v_o),
        .tag_mem_pkt_ready_i(tag_mem_pkt_ready_i),
        .stat_mem_pkt_index_o(stat_mem_pkt_index_o), .stat_mem_pkt_way_o(stat_mem_pkt_way_o),
        .stat_mem_pkt_v_o(stat_mem_pkt_v_o), .stat_mem_pkt_ready_i(stat_mem_pkt_ready_i),
        .cache_req_complete_o(cache_req_complete_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [39:0]  addr;
        logic [2:0]   way;
        logic [511:0] blk;
    } miss_t;

    miss_t       exp_q[$];
    logic [63:0] pend_beats[$];

    // Environment knobs
    int rdy_pct = 100, beat_pct = 100;
    int cmd_stall = 0, tag_stall = 0, gap_beat = -1, gap_len = 0;
    int fetch_left = 0, fill_yumis = 0, n_done = 0;
    int t_cmd = 0, t_cmd_hs = 0, t_data = 0, t_tag = 0, t_stat = 0, t_done = 0;
    logic [39:0] last_cmd;
    logic [5:0]  last_index;
    logic [2:0]  last_way;
    logic [27:0] last_tag;

    // Memory and cache-side ready drivers, updated just after each rising edge
    initial begin
        mem_cmd_ready_i = 0; mem_resp_v_i = 0; mem_resp_data_i = '0;
        data_mem_pkt_ready_i = 0; tag_mem_pkt_ready_i = 0; stat_mem_pkt_ready_i = 0;
        forever begin
            @(posedge clk_i); #1;
            mem_cmd_ready_i      = ($urandom_range(99) < rdy_pct);
            data_mem_pkt_ready_i = ($urandom_range(99) < rdy_pct);
            tag_mem_pkt_ready_i  = ($urandom_range(99) < rdy_pct);
            stat_mem_pkt_ready_i = ($urandom_range(99) < rdy_pct);
            if (mem_cmd_v_o && cmd_stall > 0) begin mem_cmd_ready_i = 0; cmd_stall--; end
            if (tag_mem_pkt_v_o && tag_stall > 0) begin tag_mem_pkt_ready_i = 0; tag_stall--; end
            mem_resp_v_i = 0;
            mem_resp_data_i = {$urandom, $urandom};
            if (fetch_left > 0 && pend_beats.size() > 0) begin
                if (gap_beat == 8 - fetch_left && gap_len > 0) gap_len--;
                else mem_resp_v_i = ($urandom_range(99) < beat_pct);
                if (mem_resp_v_i) mem_resp_data_i = pend_beats[0];
            end
        end
    end

    // Monitor: compares every DUT transfer against the front of the scoreboard
    logic p_cmd_v, p_cmd_hs, p_d_v, p_d_hs, p_t_v, p_t_hs, p_s_v, p_s_hs, p_cpl;
    logic [39:0]  p_cmd_addr;
    logic [5:0]   p_d_idx, p_t_idx, p_s_idx;
    logic [2:0]   p_d_way, p_t_way, p_s_way;
    logic [511:0] p_d_data;
    logic [27:0]  p_t_tag;
    int phase = 0;

    initial begin
        p_cmd_v = 0; p_d_v = 0; p_t_v = 0; p_s_v = 0; p_cpl = 0;
        p_cmd_hs = 0; p_d_hs = 0; p_t_hs = 0; p_s_hs = 0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                p_cmd_v = 0; p_d_v = 0; p_t_v = 0; p_s_v = 0; p_cpl = 0; phase = 0;
                continue;
            end
            // held valids must keep their fields until the transfer
            if (p_cmd_v && !p_cmd_hs) begin
                chk("cmd_v_hold", mem_cmd_v_o, 1);
                chk("cmd_addr_hold", mem_cmd_addr_o, p_cmd_addr);
            end
            if (p_d_v && !p_d_hs) begin
                chk("data_v_hold", data_mem_pkt_v_o, 1);
                chk("data_fields_hold", {data_mem_pkt_index_o, data_mem_pkt_way_o, data_mem_pkt_data_o[63:0]},
                    {p_d_idx, p_d_way, p_d_data[63:0]});
            end
            if (p_t_v && !p_t_hs) begin
                chk("tag_v_hold", tag_mem_pkt_v_o, 1);
                chk("tag_fields_hold", {tag_mem_pkt_index_o, tag_mem_pkt_way_o, tag_mem_pkt_tag_o},
                    {p_t_idx, p_t_way, p_t_tag});
            end
            if (p_s_v && !p_s_hs) begin
                chk("stat_v_hold", stat_mem_pkt_v_o, 1);
                chk("stat_fields_hold", {stat_mem_pkt_index_o, stat_mem_pkt_way_o}, {p_s_idx, p_s_way});
            end
            if (p_cpl) chk("ready_after_done", cache_req_ready_o, 1);

            if (mem_cmd_v_o && !p_cmd_v) t_cmd = cyc;
            if (mem_cmd_v_o && mem_cmd_ready_i) begin
                chk("cmd_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("cmd_addr", mem_cmd_addr_o, (exp_q[0].addr >> 6) << 6);
                last_cmd = mem_cmd_addr_o; t_cmd_hs = cyc;
                fetch_left = 8; fill_yumis = 0;
            end
            if (mem_resp_yumi_o) begin
                chk("yumi_with_v", mem_resp_v_i, 1);
                chk("yumi_in_fill", fetch_left > 0, 1);
                if (pend_beats.size() > 0) void'(pend_beats.pop_front());
                if (fetch_left > 0) fetch_left--;
                fill_yumis++;
            end
            if (data_mem_pkt_v_o && data_mem_pkt_ready_i) begin
                chk("data_order", phase, 0);
                chk("yumi_count", fill_yumis, 8);
                chk("data_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("data_index", data_mem_pkt_index_o, (exp_q[0].addr >> 6) % 64);
                    chk("data_way", data_mem_pkt_way_o, exp_q[0].way);
                    chk("data_block", data_mem_pkt_data_o, exp_q[0].blk);
                end
                last_index = data_mem_pkt_index_o; last_way = data_mem_pkt_way_o;
                t_data = cyc; phase = 1;
            end
            if (tag_mem_pkt_v_o && tag_mem_pkt_ready_i) begin
                chk("tag_order", phase, 1);
                if (exp_q.size() > 0) begin
                    chk("tag_index", tag_mem_pkt_index_o, (exp_q[0].addr >> 6) % 64);
                    chk("tag_way", tag_mem_pkt_way_o, exp_q[0].way);
                    chk("tag_value", tag_mem_pkt_tag_o, exp_q[0].addr >> 12);
                end
                last_tag = tag_mem_pkt_tag_o; t_tag = cyc; phase = 2;
            end
            if (stat_mem_pkt_v_o && stat_mem_pkt_ready_i) begin
                chk("stat_order", phase, 2);
                if (exp_q.size() > 0) begin
                    chk("stat_index", stat_mem_pkt_index_o, (exp_q[0].addr >> 6) % 64);
                    chk("stat_way", stat_mem_pkt_way_o, exp_q[0].way);
                end
                t_stat = cyc; phase = 3;
            end
            if (cache_req_complete_o) begin
                chk("complete_order", phase, 3);
                chk("ready_in_done", cache_req_ready_o, 0);
                chk("complete_width", p_cpl, 0);
                chk("complete_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_done++; t_done = cyc; phase = 0;
            end

            p_cmd_v = mem_cmd_v_o; p_cmd_hs = mem_cmd_ready_i; p_cmd_addr = mem_cmd_addr_o;
            p_d_v = data_mem_pkt_v_o; p_d_hs = data_mem_pkt_ready_i;
            p_d_idx = data_mem_pkt_index_o; p_d_way = data_mem_pkt_way_o; p_d_data = data_mem_pkt_data_o;
            p_t_v = tag_mem_pkt_v_o; p_t_hs = tag_mem_pkt_ready_i;
            p_t_idx = tag_mem_pkt_index_o; p_t_way = tag_mem_pkt_way_o; p_t_tag = tag_mem_pkt_tag_o;
            p_s_v = stat_mem_pkt_v_o; p_s_hs = stat_mem_pkt_ready_i;
            p_s_idx = stat_mem_pkt_index_o; p_s_way = stat_mem_pkt_way_o;
            p_cpl = cache_req_complete_o;
        end
    end

    // Present a miss, record its expected fill, return acceptance and metadata cycles
    task automatic issue(input logic [39:0] a, input logic [2:0] w, input int meta_dly,
                         input bit seq_beats, output int t_acc, output int t_meta);
        miss_t m;
        logic [63:0] b;
        bit ok = 0;
        m.addr = a; m.way = w; m.blk = '0;
        for (int k = 0; k < 8; k++) begin
            b = seq_beats ? 64'(k) : {$urandom, $urandom};
            m.blk[k*64 +: 64] = b;
            pend_beats.push_back(b);
        end
        exp_q.push_back(m);
        cache_req_addr_i = a; cache_req_v_i = 1;
        cache_req_metadata_v_i = (meta_dly == 0);
        cache_req_metadata_way_i = (meta_dly == 0) ? w : 3'($urandom);
        t_acc = 0; t_meta = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (cache_req_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin chk("accept_timeout", 0, 1); cache_req_v_i = 0; return; end
        t_acc = cyc; t_meta = cyc;
        @(posedge clk_i); #1;
        cache_req_v_i = 0; cache_req_addr_i = {$urandom, $urandom};
        cache_req_metadata_v_i = 0; cache_req_metadata_way_i = 3'($urandom);
        if (meta_dly > 0) begin
            repeat (meta_dly - 1) begin @(posedge clk_i); #1; end
            cache_req_metadata_v_i = 1; cache_req_metadata_way_i = w; t_meta = cyc;
            @(posedge clk_i); #1;
            cache_req_metadata_v_i = 0; cache_req_metadata_way_i = 3'($urandom);
        end
    endtask

    task automatic wait_done();
        int start = n_done;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #2;
            if (n_done > start) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic chk_all_low(input string nm);
        chk(nm, {cache_req_ready_o, mem_cmd_v_o, mem_resp_yumi_o, data_mem_pkt_v_o,
                 tag_mem_pkt_v_o, stat_mem_pkt_v_o, cache_req_complete_o}, 0);
    endtask

    int ta, tm, ta2, tm2, dn;

    initial begin
        reset_n_i = 0; cache_req_v_i = 0; cache_req_addr_i = '0;
        cache_req_metadata_v_i = 0; cache_req_metadata_way_i = '0;
        #2 chk_all_low("reset_outputs");
        repeat (3) @(posedge clk_i);
        #3 reset_n_i = 1;
        #1 chk("ready_before_edge", cache_req_ready_o, 0);
        @(posedge clk_i); #1;
        chk("ready_after_reset", cache_req_ready_o, 1);

        // basic best-case fill
        issue(40'h00_8000_1234, 3'd5, 0, 1, ta, tm);
        wait_done();
        chk("basic_cmd_addr", last_cmd, 40'h00_8000_1200);
        chk("basic_index", last_index, 6'h08);
        chk("basic_way", last_way, 3'd5);
        chk("basic_tag", last_tag, 28'h0080001);
        chk("lat_cmd", t_cmd, ta + 1);
        chk("lat_data", t_data, ta + 10);
        chk("lat_tag", t_tag, ta + 11);
        chk("lat_stat", t_stat, ta + 12);
        chk("lat_done", t_done, ta + 13);

        // metadata arriving three cycles after the request
        issue({$urandom, $urandom}, 3'd2, 3, 0, ta, tm);
        wait_done();
        chk("late_meta_cycle", tm, ta + 3);
        chk("late_meta_cmd", t_cmd, tm + 1);
        chk("late_meta_way", last_way, 3'd2);

        // backpressure on command, beats and tag
        dn = n_done;
        cmd_stall = 3; gap_beat = 4; gap_len = 2; tag_stall = 4;
        issue({$urandom, $urandom}, 3'($urandom), 0, 0, ta, tm);
        wait_done();
        chk("bp_cmd_stall", t_cmd_hs - t_cmd, 3);
        chk("bp_beat_gap", t_data - t_cmd_hs, 11);
        chk("bp_tag_stall", t_tag - t_data, 5);
        chk("bp_one_complete", n_done - dn, 1);
        gap_beat = -1;

        // back-to-back: second request held high during the first fill
        issue({$urandom, $urandom}, 3'($urandom), 0, 0, ta, tm);
        issue({$urandom, $urandom}, 3'($urandom), 0, 0, ta2, tm2);
        chk("b2b_accept", ta2, t_done + 1);
        wait_done();

        // reset in the middle of the fill after four beats
        dn = n_done;
        issue({$urandom, $urandom}, 3'($urandom), 0, 0, ta, tm);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #3;
            if (fill_yumis >= 4 && fetch_left > 0) break;
        end
        chk("reset_at_beat4", fill_yumis, 4);
        reset_n_i = 0;
        #1 chk_all_low("reset_async_outputs");
        exp_q.delete(); pend_beats.delete(); fetch_left = 0;
        repeat (2) @(posedge clk_i);
        #3 reset_n_i = 1;
        repeat (20) @(posedge clk_i);
        #2 chk("reset_no_complete", n_done, dn);
        issue({$urandom, $urandom}, 3'($urandom), 1, 0, ta, tm);
        wait_done();
        chk("post_reset_fill", n_done, dn + 1);

        // address and way extremes
        issue(40'hFF_FFFF_FFFF, 3'd7, 0, 0, ta, tm);
        wait_done();
        chk("ext_cmd_addr", last_cmd, 40'hFF_FFFF_FFC0);
        chk("ext_index", last_index, 6'h3F);
        chk("ext_way", last_way, 3'd7);
        chk("ext_tag", last_tag, 28'hFFFFFFF);

        // randomized traffic with random readiness
        rdy_pct = 65; beat_pct = 60;
        dn = n_done;
        for (int i = 0; i < 30; i++)
            issue({$urandom, $urandom}, 3'($urandom), $urandom_range(3), 0, ta, tm);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk_i);
        #2 chk("rand_all_done", n_done - dn, 30);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("beats_consumed", pend_beats.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/bp_fe_icache_fill_responder.md
Name: bp_fe_icache_fill_responder

Overview:
- LCE-side responder for the I-cache miss interface.
- Accepts one miss request plus its replacement-way metadata, and fetches the block from a narrow memory port in beats.
- Fills the cache through data, tag and stat memory packets, in that order, then pulses cache_req_complete_o.
- Sits between the FE I-cache miss outputs and the memory/CCE side. Strictly one outstanding miss.

Parameters:
- paddr_width_p, 40, physical address width
- icache_sets_p, 64, I-cache sets; index_width = clog2(sets) = 6
- icache_assoc_p, 8, ways; way_width = clog2(assoc) = 3
- icache_block_width_p, 512, block bits; block_offset_width = clog2(block_width/8) = 6
- mem_data_width_p, 64, memory beat width; beats_lp = block_width/mem_data_width = 8
- ptag_width_p, 28, physical tag width; must equal paddr_width - 12

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- cache_req_addr_i  in  paddr_width_p  miss physical address
- cache_req_v_i  in  1  miss request valid
- cache_req_ready_o  out  1  responder idle, can accept a request
- cache_req_metadata_way_i  in  way_width  victim way
- cache_req_metadata_v_i  in  1  metadata valid
- mem_cmd_addr_o  out  paddr_width_p  block-aligned fetch address
- mem_cmd_v_o  out  1  fetch command valid
- mem_cmd_ready_i  in  1  memory accepts command
- mem_resp_data_i  in  mem_data_width_p  response beat
- mem_resp_v_i  in  1  beat valid
- mem_resp_yumi_o  out  1  beat consumed
- data_mem_pkt_index_o  out  index_width  fill set
- data_mem_pkt_way_o  out  way_width  fill way
- data_mem_pkt_data_o  out  icache_block_width_p  fill block
- data_mem_pkt_v_o  out  1  data packet valid
- data_mem_pkt_ready_i  in  1  cache accepts data packet
- tag_mem_pkt_index_o  out  index_width  tag set
- tag_mem_pkt_way_o  out  way_width  tag way
- tag_mem_pkt_tag_o  out  ptag_width_p  tag value
- tag_mem_pkt_v_o  out  1  tag packet valid
- tag_mem_pkt_ready_i  in  1  cache accepts tag packet
- stat_mem_pkt_index_o  out  index_width  LRU set
- stat_mem_pkt_way_o  out  way_width  way to mark MRU
- stat_mem_pkt_v_o  out  1  stat packet valid
- stat_mem_pkt_ready_i  in  1  cache accepts stat packet
- cache_req_complete_o  out  1  one-cycle fill-done pulse

Behaviour:
- FSM states: IDLE, WAIT_META, SEND_MEM, FILL, WR_DATA, WR_TAG, WR_STAT, DONE.
- Reset (reset_n_i low, async): state = IDLE; beat counter, address, way and block registers cleared.
  - All v_o outputs, mem_resp_yumi_o, cache_req_complete_o and cache_req_ready_o are 0 while reset is asserted.
  - cache_req_ready_o goes to 1 on the first clock edge after deassertion.
- IDLE: cache_req_ready_o = 1. On cache_req_v_i, latch the address.
  - If cache_req_metadata_v_i is also high in that cycle, latch the way and go to SEND_MEM; otherwise go to WAIT_META.
  - cache_req_ready_o is 0 in every other state.
- WAIT_META: on cache_req_metadata_v_i, latch the way and go to SEND_MEM. Metadata_v outside IDLE and WAIT_META is ignored.
- SEND_MEM: mem_cmd_v_o = 1; mem_cmd_addr_o = latched address with the low 6 bits zeroed. Leave on mem_cmd_ready_i.
- FILL: mem_resp_yumi_o = mem_resp_v_i. Each accepted beat k (0..7, in order) is written to block bits [k*64 +: 64].
  - The 3-bit counter increments per beat; after beat 7 the counter wraps to 0 and the FSM goes to WR_DATA.
  - Gaps between beats are allowed.
- Packet fields in all WR_* states:
  - index = addr[11:6]
  - way = latched way
  - tag = addr[39:12]
- WR_DATA: data_mem_pkt_v_o = 1; advance when data_mem_pkt_ready_i is high.
- WR_TAG: tag_mem_pkt_v_o = 1; advance when tag_mem_pkt_ready_i is high.
- WR_STAT: stat_mem_pkt_v_o = 1; advance when stat_mem_pkt_ready_i is high.
- Write ordering is data, then tag, then stat, so a tag is never valid before its data is present.
- Handshake rules: a packet transfers on the cycle where v and ready are both high. v may be asserted before ready, and v never drops until the transfer.
- DONE: cache_req_complete_o = 1 for exactly one cycle, then IDLE.
- Best-case latency: request accepted at T with metadata, all readies high, beats back-to-back.
  - Memory command at T+1, beats T+2..T+9, data packet T+10, tag packet T+11, stat packet T+12.
  - Complete pulse at T+13; ready again at T+14.
- Reset mid-operation: immediate abort, in-flight beats discarded, no complete pulse. The memory side must be reset together with this block.

Test Plan:
- Basic fill: req addr 0x00_8000_1234 with meta way 5 in the same cycle, all readies high, beats 0x0..0x7.
  - Required: mem_cmd_addr 0x00_8000_1200; data_pkt index 0x08, way 5, data word k = k.
  - Required: tag 0x0080001; stat way 5; complete at T+13.
- Late metadata: req at T, meta way 2 at T+3.
  - Required: mem_cmd_v_o first high at T+4; packets carry way 2.
- Backpressure: mem_cmd_ready low 3 cycles, gap of 2 cycles after beat 3, tag ready low 4 cycles.
  - Required: every v stays high and its fields stay stable until its handshake.
  - Required: exactly 8 yumis; exactly one complete pulse.
- Back-to-back misses: second req presented during DONE.
  - Required: cache_req_ready_o is 0 during DONE, so the second req is not accepted then.
  - Required: it is accepted the following cycle and is serviced correctly.
- Reset during FILL after 4 beats.
  - Required: all outputs 0 asynchronously; no packet or complete pulse.
  - Required: a subsequent miss fills a correct block with the beat counter starting at 0.
- Index/tag extremes: addr 0xFF_FFFF_FFFF, way 7.
  - Required: index 0x3F, tag 0xFFFFFFF, mem_cmd_addr 0xFF_FFFF_FFC0.
